// File: rtl/cc_refill_writer_pkg.sv
// Shared definitions for the cache refill path.
//   - Address geometry: TAG_W / IDX_W / OFF_W and the memory beat width DATA_W.
//   - Derived sizes: BEATS_PER_LINE and BEAT_W.
//   - FSM state enum for the refill writer.
//   - Helpers:
//       line_addr(tag, index) builds the line-aligned byte address.
//       beat_of(offset)       gives the beat number that holds a byte offset.
package cc_pkg;
  localparam int TAG_W          = 18;
  localparam int IDX_W          = 8;
  localparam int OFF_W          = 6;
  localparam int DATA_W         = 64;
  localparam int WORD_W         = 32;
  localparam int ADDR_W         = TAG_W + IDX_W + OFF_W;
  localparam int BEATS_PER_LINE = (2**OFF_W) * 8 / DATA_W;
  localparam int BEAT_W         = $clog2(BEATS_PER_LINE);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_FILL, S_DONE} state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] index);
    return {tag, index, {OFF_W{1'b0}}};
  endfunction

  // Upper offset bits select the beat; the low bits address bytes within it.
  function automatic logic [BEAT_W-1:0] beat_of(input logic [OFF_W-1:0] offset);
    return BEAT_W'(offset >> (OFF_W - BEAT_W));
  endfunction
endpackage

// File: rtl/cc_refill_writer_if.sv
// Memory read channel between the refill writer and the memory controller.
//   master : refill writer side (drives AR request and R ready).
//   slave  : memory side (drives AR ready and R data/valid/last).
interface cc_refill_writer_if;
  import cc_pkg::*;
  logic              mem_arvalid_o;
  logic [ADDR_W-1:0] mem_araddr_o;
  logic [3:0]        mem_arlen_o;
  logic              mem_arready_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_rlast_i;
  logic              mem_rready_o;

  modport master (
    output mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_rready_o,
    input  mem_arready_i, mem_rvalid_i, mem_rdata_i, mem_rlast_i
  );
  modport slave (
    input  mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_rready_o,
    output mem_arready_i, mem_rvalid_i, mem_rdata_i, mem_rlast_i
  );
endinterface

// File: rtl/cc_crit_word_sel.sv
// Picks the 32-bit word out of a 64-bit memory beat.
//   i_beat   : beat data
//   i_sel_hi : byte offset bit 2 (1 = upper word)
//   o_word   : selected word
module cc_crit_word_sel
  import cc_pkg::*;
(
  input  logic [DATA_W-1:0] i_beat,
  input  logic              i_sel_hi,
  output logic [WORD_W-1:0] o_word
);
  assign o_word = i_sel_hi ? i_beat[DATA_W-1 -: WORD_W] : i_beat[WORD_W-1:0];
endmodule

// File: rtl/cc_refill_writer.sv
// Cache miss refill writer.
// On a miss pulse, issues one line burst read, writes each returned beat
// into the data SRAM, and forwards the critical word to the requester.
// It then writes {valid,tag} into the tag SRAM and pulses fill_done.
//   clk, rst           : clock, synchronous active-high reset
//   miss_i/tag_i/...   : miss request from the lookup stage
//   busy_o             : refill in progress
//   mem                : memory read channel (AR + R)
//   data_w*_o          : data SRAM write port
//   tag_w*_o           : tag SRAM write port
//   crit_valid_o/data  : critical word forward
//   fill_done_o, err_o : completion pulse, sticky burst-length error
module cc_refill_writer
  import cc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic [IDX_W-1:0]        index_i,
  input  logic [OFF_W-1:0]        offset_i,
  output logic                    busy_o,
  cc_refill_writer_if.master      mem,
  output logic                    data_wren_o,
  output logic [IDX_W+BEAT_W-1:0] data_waddr_o,
  output logic [DATA_W-1:0]       data_wdata_o,
  output logic                    tag_wren_o,
  output logic [IDX_W-1:0]        tag_waddr_o,
  output logic [TAG_W:0]          tag_wdata_o,
  output logic                    crit_valid_o,
  output logic [WORD_W-1:0]       crit_data_o,
  output logic                    fill_done_o,
  output logic                    err_o
);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

  state_t            r_state, w_state_nxt;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_index;
  logic [BEAT_W-1:0] r_beat, r_crit_beat;
  logic              r_crit_hi;
  logic              w_arvalid, w_rready, w_busy;
  logic              w_accept, w_last, w_good, w_crit_hit;
  logic [WORD_W-1:0] w_crit_word;
  logic              w_unused_off;

  // Byte-within-word offset bits do not affect a word-granular forward.
  assign w_unused_off = ^offset_i[1:0];

  assign w_accept   = (r_state == S_FILL) & mem.mem_rvalid_i;
  // Beat 7 always ends the fill, with or without rlast; an early rlast also ends it.
  assign w_last     = w_accept & (mem.mem_rlast_i | (r_beat == LAST_BEAT));
  // Only a burst whose rlast lands exactly on beat 7 makes the line valid.
  assign w_good     = w_last & mem.mem_rlast_i & (r_beat == LAST_BEAT);
  assign w_crit_hit = w_accept & (r_beat == r_crit_beat);

  cc_crit_word_sel u_crit_sel (
    .i_beat   (mem.mem_rdata_i),
    .i_sel_hi (r_crit_hi),
    .o_word   (w_crit_word)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (miss_i) w_state_nxt = S_AR;
      end
      S_AR: begin
        w_arvalid = 1'b1;
        if (mem.mem_arready_i) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        w_rready = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy_o            = w_busy;
  assign mem.mem_arvalid_o = w_arvalid;
  assign mem.mem_rready_o  = w_rready;
  assign mem.mem_araddr_o  = line_addr(r_tag, r_index);
  assign mem.mem_arlen_o   = 4'(BEATS_PER_LINE - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag        <= '0;
      r_index      <= '0;
      r_beat       <= '0;
      r_crit_beat  <= '0;
      r_crit_hi    <= 1'b0;
      data_wren_o  <= 1'b0;
      data_waddr_o <= '0;
      data_wdata_o <= '0;
      tag_wren_o   <= 1'b0;
      tag_waddr_o  <= '0;
      tag_wdata_o  <= '0;
      crit_valid_o <= 1'b0;
      crit_data_o  <= '0;
      fill_done_o  <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      data_wren_o  <= w_accept;
      crit_valid_o <= w_crit_hit;
      tag_wren_o   <= w_good;
      fill_done_o  <= w_last;
      if (w_accept) begin
        data_waddr_o <= {r_index, r_beat};
        data_wdata_o <= mem.mem_rdata_i;
        r_beat       <= r_beat + 1'b1;
      end
      if (w_crit_hit) crit_data_o <= w_crit_word;
      if (w_good) begin
        tag_waddr_o <= r_index;
        tag_wdata_o <= {1'b1, r_tag};
      end
      if (w_last && !w_good) err_o <= 1'b1;
      if (r_state == S_IDLE && miss_i) begin
        r_tag       <= tag_i;
        r_index     <= index_i;
        r_crit_beat <= beat_of(offset_i);
        r_crit_hi   <= offset_i[2];
        r_beat      <= '0;
        err_o       <= 1'b0;
      end
    end
  end
endmodule
